// File: rtl/frame_writer.sv
// frame_writer: drains the compute-side pixel-out FIFO into SDRAM in fixed-length
// write bursts. It walks one frame linearly from address 0, pulses frame-done after
// the last word and wraps back to 0. The SDRAM interface is shared with the scan-out
// read path through a request/grant pair owned by the top-level arbiter.
module frame_writer #(
    parameter int WRITE_BURST_LENGTH = 8,
    parameter int FRAME_WORDS        = 96000,
    parameter int FIFO_DEPTH         = 1024
) (
    input  logic                          i_Clk,
    input  logic                          i_Reset,
    input  logic [$clog2(FIFO_DEPTH)-1:0] i_Pixel_Out_Used,
    input  logic [31:0]                   i_Pixel_Out_Data,
    input  logic                          i_Data_Write_Done,
    input  logic                          i_Grant,
    input  logic                          i_Frame_Start,
    output logic                          o_Request,
    output logic [1:0]                    o_Command,
    output logic [21:0]                   o_Data_Address,
    output logic [31:0]                   o_Data_Write,
    output logic                          o_FIFO_Rd,
    output logic                          o_Frame_Done
);

    // Command encodings shared with the SDRAM controller and the read path.
    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    localparam int USED_W  = $clog2(FIFO_DEPTH);
    localparam int COUNT_W = (WRITE_BURST_LENGTH > 1) ? $clog2(WRITE_BURST_LENGTH) : 1;

    localparam logic [USED_W-1:0]  BURST_USED  = USED_W'(WRITE_BURST_LENGTH);
    localparam logic [COUNT_W-1:0] BURST_LOAD  = COUNT_W'(WRITE_BURST_LENGTH - 1);
    localparam logic [21:0]        LAST_ADDR   = 22'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [21:0]          addr_q, addr_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 pending_q, pending_d;
    logic                 done_q, done_d;
    logic                 request_q, request_d;
    logic [1:0]           command_q, command_d;
    logic                 accept;

    // A word is accepted only while the registered command says WRITE; the
    // pop and the data pass-through are combinational so the show-ahead head
    // word is presented with zero latency.
    always_comb begin
        accept         = (command_q == CMD_WRITE) && i_Data_Write_Done;
        o_FIFO_Rd      = accept;
        o_Data_Write   = i_Pixel_Out_Data;
        o_Request      = request_q;
        o_Command      = command_q;
        o_Data_Address = addr_q;
        o_Frame_Done   = done_q;
    end

    // Next-state logic: burst sequencing, address walk with frame wrap, and
    // frame-start handling (deferred to the end of a burst once one has begun).
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        count_d   = count_q;
        pending_d = pending_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_Pixel_Out_Used >= BURST_USED) begin
                    state_d = ST_REQ;
                end
                if (i_Frame_Start) begin
                    addr_d = '0;
                end
            end

            ST_REQ: begin
                if (i_Grant) begin
                    state_d = ST_WRITE;
                    count_d = BURST_LOAD;
                end
                if (i_Frame_Start) begin
                    addr_d = '0;
                end
            end

            ST_WRITE: begin
                if (i_Frame_Start) begin
                    pending_d = 1'b1;
                end
                if (accept) begin
                    count_d = count_q - COUNT_W'(1);
                    if (addr_q == LAST_ADDR) begin
                        addr_d = '0;
                        done_d = 1'b1;
                    end else begin
                        addr_d = addr_q + 22'd1;
                    end
                    if (count_q == '0) begin
                        state_d = ST_IDLE;
                        if (pending_q || i_Frame_Start) begin
                            addr_d = '0;
                        end
                        pending_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        request_d = (state_d != ST_IDLE);
        command_d = (state_d == ST_WRITE) ? CMD_WRITE : CMD_IDLE;
    end

    // State and registered outputs; reset aborts any burst in flight.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            request_q <= 1'b0;
            command_q <= CMD_IDLE;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            request_q <= request_d;
            command_q <= command_d;
        end
    end

endmodule
